// File: rtl/dffram_arb_pkg.sv
// Shared types for the DFFRAM two-port arbiter: port identifiers, the
// response record and the byte-enable width helper.
package dffram_arb_pkg;

  typedef enum logic {
    PORT_INSTR = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  // One outstanding response: who owns it and how to shape the return data.
  typedef struct packed {
    logic  valid;
    port_e port;
    logic  err;
    logic  write;
  } resp_t;

  localparam int BYTE_W = 8;

  function automatic int be_width(input int data_w);
    return data_w / BYTE_W;
  endfunction

endpackage

// File: rtl/dffram_arb_prio.sv
// Winner selection between instruction fetch and data access. Data normally
// wins; a saturating starvation counter hands priority to instruction fetch
// once it has been denied STARVE_LIMIT consecutive cycles.
module dffram_arb_prio
  import dffram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic instr_req_i,
  input  logic data_req_i,
  output logic instr_win_o,
  output logic data_win_o
);

  logic [3:0] starve_q;
  logic       instr_prio;

  // Pick at most one winner; nothing is granted while reset is asserted.
  always_comb begin
    instr_prio  = instr_req_i && (starve_q == 4'(STARVE_LIMIT));
    data_win_o  = rst_ni && data_req_i && !instr_prio;
    instr_win_o = rst_ni && instr_req_i && !data_win_o;
  end

  // Count consecutive denied instruction-request cycles, saturating at the limit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= 4'd0;
    end else if (instr_req_i && !instr_win_o) begin
      if (starve_q != 4'(STARVE_LIMIT)) starve_q <= starve_q + 4'd1;
    end else begin
      starve_q <= 4'd0;
    end
  end

endmodule

// File: rtl/dffram_arbiter.sv
// Shares one single-port DFFRAM between instruction fetch and data access:
// arbitration, byte-to-word address translation with range/alignment check,
// memory drive, and routing of the one-cycle-late response to its owner.
module dffram_arbiter
  import dffram_arb_pkg::*;
#(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          instr_req_i,
  input  logic                          instr_we_i,
  input  logic [be_width(DATA_W)-1:0]   instr_be_i,
  input  logic [31:0]                   instr_addr_i,
  input  logic [DATA_W-1:0]             instr_wdata_i,
  output logic                          instr_gnt_o,
  output logic                          instr_rvalid_o,
  output logic [DATA_W-1:0]             instr_rdata_o,
  output logic                          instr_err_o,
  input  logic                          data_req_i,
  input  logic                          data_we_i,
  input  logic [be_width(DATA_W)-1:0]   data_be_i,
  input  logic [31:0]                   data_addr_i,
  input  logic [DATA_W-1:0]             data_wdata_i,
  output logic                          data_gnt_o,
  output logic                          data_rvalid_o,
  output logic [DATA_W-1:0]             data_rdata_o,
  output logic                          data_err_o,
  output logic                          mem_en_o,
  output logic [be_width(DATA_W)-1:0]   mem_we_o,
  output logic [DATA_W-1:0]             mem_di_o,
  output logic [ADDR_W-1:0]             mem_a_o,
  input  logic [DATA_W-1:0]             mem_do_i
);

  localparam int BE_W = be_width(DATA_W);

  logic              instr_gnt;
  logic              data_gnt;
  logic              any_gnt;
  logic              addr_err;
  logic              sel_we;
  logic [BE_W-1:0]   sel_be;
  logic [31:0]       sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              read_ok;
  resp_t             resp_q;

  dffram_arb_prio #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .instr_req_i (instr_req_i),
    .data_req_i  (data_req_i),
    .instr_win_o (instr_gnt),
    .data_win_o  (data_gnt)
  );

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  // Mux the granted request onto the memory; illegal addresses never enable it.
  always_comb begin
    any_gnt   = instr_gnt || data_gnt;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (data_gnt) begin
      sel_we    = data_we_i;
      sel_be    = data_be_i;
      sel_addr  = data_addr_i;
      sel_wdata = data_wdata_i;
    end else if (instr_gnt) begin
      sel_we    = instr_we_i;
      sel_be    = instr_be_i;
      sel_addr  = instr_addr_i;
      sel_wdata = instr_wdata_i;
    end
    addr_err = (sel_addr[1:0] != 2'b00) || (sel_addr[31:ADDR_W+2] != '0);
    mem_en_o = any_gnt && !addr_err;
    mem_a_o  = sel_addr[ADDR_W+1:2];
    mem_di_o = sel_wdata;
    mem_we_o = (mem_en_o && sel_we) ? sel_be : '0;
  end

  // Capture who owns next cycle's response; reset drops any pending one.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resp_q <= '0;
    end else if (any_gnt) begin
      resp_q.valid <= 1'b1;
      resp_q.port  <= data_gnt ? PORT_DATA : PORT_INSTR;
      resp_q.err   <= addr_err;
      resp_q.write <= sel_we;
    end else begin
      resp_q.valid <= 1'b0;
    end
  end

  // Route the response to its owner; read data only for a legal read.
  always_comb begin
    read_ok        = !resp_q.err && !resp_q.write;
    instr_rvalid_o = resp_q.valid && (resp_q.port == PORT_INSTR);
    data_rvalid_o  = resp_q.valid && (resp_q.port == PORT_DATA);
    instr_err_o    = instr_rvalid_o && resp_q.err;
    data_err_o     = data_rvalid_o && resp_q.err;
    instr_rdata_o  = (instr_rvalid_o && read_ok) ? mem_do_i : '0;
    data_rdata_o   = (data_rvalid_o && read_ok) ? mem_do_i : '0;
  end

endmodule

// File: tb/tb_dffram_arbiter.sv
// Randomized and directed bench for dffram_arbiter with a behavioural memory
// and a transaction-level reference model of arbitration and responses.
module tb_dffram_arbiter;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int LIMIT  = 4;
  localparam int DEPTH  = 1 << ADDR_W;

  logic              clk;
  logic              rst_n;
  logic              instr_req, instr_we;
  logic [3:0]        instr_be;
  logic [31:0]       instr_addr, instr_wdata;
  logic              instr_gnt, instr_rvalid, instr_err;
  logic [31:0]       instr_rdata;
  logic              data_req, data_we;
  logic [3:0]        data_be;
  logic [31:0]       data_addr, data_wdata;
  logic              data_gnt, data_rvalid, data_err;
  logic [31:0]       data_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [31:0]       mem_di;
  logic [ADDR_W-1:0] mem_a;
  logic [31:0]       mem_do;

  dffram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .instr_req_i(instr_req), .instr_we_i(instr_we), .instr_be_i(instr_be),
    .instr_addr_i(instr_addr), .instr_wdata_i(instr_wdata),
    .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
    .data_addr_i(data_addr), .data_wdata_i(data_wdata),
    .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_di_o(mem_di),
    .mem_a_o(mem_a), .mem_do_i(mem_do)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural DFFRAM: read-first, registered read data, byte-write mask.
  logic [31:0] ram [0:DEPTH-1];
  always @(posedge clk) begin
    if (mem_en) begin
      mem_do <= ram[mem_a];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) ram[mem_a][b*8 +: 8] <= mem_di[b*8 +: 8];
    end
  end

  // Reference model state
  logic [31:0] ref_mem [0:DEPTH-1];
  int          m_starve;
  logic        p_valid, p_port, p_err;
  logic [31:0] p_rdata;

  // Observations captured at the checking edge
  logic        obs_ig, obs_dg, obs_men, obs_irv, obs_drv, obs_derr;
  logic [ADDR_W-1:0] obs_mema;
  logic [3:0]  obs_mwe;
  logic [31:0] obs_drdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic set_i(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    instr_req = req; instr_we = we; instr_be = be; instr_addr = addr; instr_wdata = wd;
  endtask

  task automatic set_d(input logic req, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    data_req = req; data_we = we; data_be = be; data_addr = addr; data_wdata = wd;
  endtask

  // Check one cycle against the model at the falling edge, then advance.
  task automatic run_cycle();
    logic eig, edg, legal, we, en;
    logic [31:0] a, wd, nw;
    logic [3:0] be;
    logic [ADDR_W-1:0] idx;
    @(negedge clk);
    if (!rst_n) p_valid = 1'b0;
    edg = rst_n && data_req && !(instr_req && (m_starve == LIMIT));
    eig = rst_n && instr_req && !edg;
    we = 1'b0; be = '0; a = '0; wd = '0;
    if (edg) begin we = data_we; be = data_be; a = data_addr; wd = data_wdata; end
    else if (eig) begin we = instr_we; be = instr_be; a = instr_addr; wd = instr_wdata; end
    legal = (a % 4 == 0) && (a < 32'(DEPTH * 4));
    idx = ADDR_W'(a / 4);
    en = (eig || edg) && legal;
    chk("instr_gnt", instr_gnt, eig);
    chk("data_gnt", data_gnt, edg);
    chk("mem_en", mem_en, en);
    chk("mem_we", mem_we, (en && we) ? be : 4'h0);
    chk("mem_a", mem_a, idx);
    chk("mem_di", mem_di, wd);
    chk("instr_rvalid", instr_rvalid, p_valid && !p_port);
    chk("instr_err", instr_err, p_valid && !p_port && p_err);
    chk("instr_rdata", instr_rdata, (p_valid && !p_port) ? p_rdata : 32'h0);
    chk("data_rvalid", data_rvalid, p_valid && p_port);
    chk("data_err", data_err, p_valid && p_port && p_err);
    chk("data_rdata", data_rdata, (p_valid && p_port) ? p_rdata : 32'h0);
    obs_ig = instr_gnt; obs_dg = data_gnt; obs_men = mem_en; obs_mema = mem_a;
    obs_mwe = mem_we; obs_irv = instr_rvalid; obs_drv = data_rvalid;
    obs_derr = data_err; obs_drdata = data_rdata;
    if (!rst_n) begin
      p_valid = 1'b0;
      m_starve = 0;
    end else begin
      if (eig || edg) begin
        p_valid = 1'b1;
        p_port  = edg;
        p_err   = !legal;
        p_rdata = (legal && !we) ? ref_mem[idx] : 32'h0;
        if (legal && we) begin
          nw = ref_mem[idx];
          for (int b = 0; b < 4; b++) if (be[b]) nw[b*8 +: 8] = wd[b*8 +: 8];
          ref_mem[idx] = nw;
        end
      end else begin
        p_valid = 1'b0;
      end
      if (instr_req && !eig) m_starve = (m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1;
      else m_starve = 0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom % 10;
    if (r < 8) return 32'($urandom % 8) << 2;
    else if (r == 8) return (32'($urandom % 8) << 2) | 32'($urandom % 3 + 1);
    else return ($urandom | 32'h4000) & 32'hFFFF_FFFC;
  endfunction

  logic instr_pending;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin ram[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem_do = 32'h0;
    m_starve = 0; p_valid = 1'b0; p_port = 1'b0; p_err = 1'b0; p_rdata = 32'h0;

    // Reset held with both requesters active
    rst_n = 1'b0;
    set_i(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    set_d(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    run_cycle();
    chk("rst_men", obs_men, 1'b0);
    run_cycle();
    rst_n = 1'b1;
    run_cycle();
    chk("rst_rel_dgnt", obs_dg, 1'b1);
    set_i(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle();

    // Write then read back the same word
    set_d(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
    run_cycle();
    chk("wr_mem_a", obs_mema, 4);
    set_d(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    run_cycle();
    chk("rd_mem_a", obs_mema, 4);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle();
    chk("raw_rdata", obs_drdata, 32'hDEADBEEF);
    chk("raw_err", obs_derr, 1'b0);

    // Partial byte mask
    set_d(1'b1, 1'b1, 4'hF, 32'h20, 32'h11223344);
    run_cycle();
    set_d(1'b1, 1'b1, 4'h5, 32'h20, 32'hAABBCCDD);
    run_cycle();
    set_d(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    run_cycle();
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle();
    chk("mask_rdata", obs_drdata, 32'h11BB33DD);

    // Starvation: continuous contention
    set_i(1'b1, 1'b0, 4'h0, 32'h8, 32'h0);
    set_d(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    for (int i = 0; i < 10; i++) begin
      run_cycle();
      chk("starve_igrant", obs_ig, (i % 5) == 4);
      chk("starve_dgrant", obs_dg, (i % 5) != 4);
    end
    set_i(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle();

    // Misaligned and out-of-range accesses
    set_d(1'b1, 1'b0, 4'h0, 32'h2, 32'h0);
    run_cycle();
    chk("err1_men", obs_men, 1'b0);
    set_d(1'b1, 1'b1, 4'hF, 32'h4000, 32'h12345678);
    run_cycle();
    chk("err2_men", obs_men, 1'b0);
    chk("err2_mwe", obs_mwe, 4'h0);
    chk("err1_rvalid", obs_drv, 1'b1);
    chk("err1_err", obs_derr, 1'b1);
    chk("err1_rdata", obs_drdata, 32'h0);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle();
    chk("err2_rvalid", obs_drv, 1'b1);
    chk("err2_err", obs_derr, 1'b1);

    // Interleaved responses in grant order
    set_i(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    run_cycle();
    set_i(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    run_cycle();
    chk("ilv_irvalid", obs_irv, 1'b1);
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle();
    chk("ilv_drvalid", obs_drv, 1'b1);
    chk("ilv_irvalid2", obs_irv, 1'b0);

    // Same, with reset pulsed in the second cycle
    set_i(1'b1, 1'b0, 4'h0, 32'h10, 32'h0);
    run_cycle();
    set_i(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_d(1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    rst_n = 1'b0;
    run_cycle();
    chk("rstp_irvalid", obs_irv, 1'b0);
    chk("rstp_dgnt", obs_dg, 1'b0);
    rst_n = 1'b1;
    set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    run_cycle();
    chk("rstp_drvalid", obs_drv, 1'b0);

    // Randomized traffic; instr holds its request until granted
    instr_pending = 1'b0;
    for (int c = 0; c < 800; c++) begin
      if (!instr_pending)
        set_i(1'($urandom % 2), 1'($urandom % 2), 4'($urandom), rand_addr(), $urandom);
      set_d(1'(($urandom % 10) < 7), 1'($urandom % 2), 4'($urandom), rand_addr(), $urandom);
      rst_n = ($urandom % 100) != 0;
      run_cycle();
      instr_pending = rst_n && instr_req && !obs_ig;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
